// File: rtl/clint_bus_slave_if.sv
// rtl/clint_bus_slave_if.sv - core load/store request/response bus toward the CLINT responder
interface clint_bus_slave_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_wen;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_addr, req_wen, req_wdata, req_wstrb, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_wen, req_wdata, req_wstrb, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/clint_bus_slave.sv
// rtl/clint_bus_slave.sv - bus responder for CLINT mtime/mtimecmp with byte-strobe merge
// Optional msip register enabled by defining CLINT_MSIP_EN.
module clint_bus_slave #(
  parameter logic [31:0] BASE_ADDR    = 32'h0200_0000,
  parameter logic [31:0] MTIMECMP_OFF = 32'h0000_4000,
  parameter logic [31:0] MTIME_OFF    = 32'h0000_BFF8
) (
  input  logic                 clk,
  input  logic                 reset,
  clint_bus_slave_if.slave     bus,
  output logic [63:0]          clint_wdata,
  output logic                 clint_mtime_en,
  output logic                 clint_mtimecmp_en,
  input  logic [63:0]          clint_mtime_data,
  input  logic [63:0]          clint_mtimecmp_data
`ifdef CLINT_MSIP_EN
  ,
  output logic                 msip_int
`endif
);

  localparam logic [31:0] MTIME_ADDR    = BASE_ADDR + MTIME_OFF;
  localparam logic [31:0] MTIMECMP_ADDR = BASE_ADDR + MTIMECMP_OFF;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q;
  logic        wen_q;
  logic [63:0] wdata_q;
  logic [7:0]  wstrb_q;
  logic [63:0] wdata_hold_q;
  logic [63:0] rdata_q;
  logic        err_q;

  logic        aligned, hit_mtime, hit_cmp, hit_msip, hit;
  logic [63:0] cur, mask, merged;
  logic        do_write, accept;

`ifdef CLINT_MSIP_EN
  logic msip_q;
  assign msip_int = msip_q;
  assign hit_msip = (addr_q == BASE_ADDR);
`else
  assign hit_msip = 1'b0;
`endif

  assign accept = bus.req_valid && bus.req_ready;

  // Decode and merge are purely combinational on the latched request so the
  // live CLINT value is merged in the same cycle the enable fires.
  always_comb begin
    aligned   = (addr_q[2:0] == 3'b000);
    hit_mtime = (addr_q == MTIME_ADDR);
    hit_cmp   = (addr_q == MTIMECMP_ADDR);
    hit       = aligned && (hit_mtime || hit_cmp || hit_msip);
    cur       = 64'd0;
    if (hit_mtime)
      cur = clint_mtime_data;
    else if (hit_cmp)
      cur = clint_mtimecmp_data;
`ifdef CLINT_MSIP_EN
    else if (hit_msip)
      cur = {63'd0, msip_q};
`endif
    mask = 64'd0;
    for (int i = 0; i < 8; i++)
      mask[8*i +: 8] = {8{wstrb_q[i]}};
    merged   = (cur & ~mask) | (wdata_q & mask);
    do_write = (state_q == EXEC) && hit && wen_q && (wstrb_q != 8'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready     = (state_q == IDLE) && !reset;
    bus.rsp_valid     = (state_q == RESP);
    bus.rsp_rdata     = rdata_q;
    bus.rsp_err       = err_q;
    clint_mtime_en    = do_write && hit_mtime;
    clint_mtimecmp_en = do_write && hit_cmp;
    clint_wdata       = (do_write && (hit_mtime || hit_cmp)) ? merged : wdata_hold_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q       <= 32'd0;
      wen_q        <= 1'b0;
      wdata_q      <= 64'd0;
      wstrb_q      <= 8'd0;
      wdata_hold_q <= 64'd0;
      rdata_q      <= 64'd0;
      err_q        <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= bus.req_addr;
        wen_q   <= bus.req_wen;
        wdata_q <= bus.req_wdata;
        wstrb_q <= bus.req_wstrb;
      end
      if (state_q == EXEC) begin
        err_q   <= !hit;
        rdata_q <= (hit && !wen_q) ? cur : 64'd0;
        if (do_write && (hit_mtime || hit_cmp))
          wdata_hold_q <= merged;
      end
    end
  end

`ifdef CLINT_MSIP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      msip_q <= 1'b0;
    else if (do_write && hit_msip && wstrb_q[0])
      msip_q <= wdata_q[0];
  end
`endif

endmodule

// File: tb/tb_clint_bus_slave.sv
// tb/tb_clint_bus_slave.sv - directed self-checking bench for clint_bus_slave
// Set CLINT_MSIP_EN to exercise the msip register.
module tb_clint_bus_slave;
  localparam logic [31:0] A_BASE  = 32'h0200_0000;
  localparam logic [31:0] A_CMP   = 32'h0200_4000;
  localparam logic [31:0] A_MTIME = 32'h0200_BFF8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [63:0] clint_wdata;
  logic        clint_mtime_en, clint_mtimecmp_en;
  logic [63:0] mtime_q, mtimecmp_q;
  logic        msip_model = 1'b0;
  int          n_checks = 0, n_fail = 0;
  int          n_mt_en = 0, n_cmp_en = 0;
`ifdef CLINT_MSIP_EN
  logic        msip_int;
`endif

  clint_bus_slave_if bus ();

  clint_bus_slave dut (
    .clk                 (clk),
    .reset               (reset),
    .bus                 (bus),
    .clint_wdata         (clint_wdata),
    .clint_mtime_en      (clint_mtime_en),
    .clint_mtimecmp_en   (clint_mtimecmp_en),
    .clint_mtime_data    (mtime_q),
    .clint_mtimecmp_data (mtimecmp_q)
`ifdef CLINT_MSIP_EN
    ,
    .msip_int            (msip_int)
`endif
  );

  always #5 clk = ~clk;

  // CLINT stand-in: free-running mtime, write port overrides increment
  always @(posedge clk) begin
    if (reset) begin
      mtime_q    <= 64'h0000_0001_FFFF_FFF0;
      mtimecmp_q <= 64'hFFFF_FFFF_FFFF_FFFF;
    end else begin
      mtime_q <= clint_mtime_en ? clint_wdata : mtime_q + 64'd1;
      if (clint_mtimecmp_en) mtimecmp_q <= clint_wdata;
    end
  end

  always @(negedge clk) begin
    if (clint_mtime_en) n_mt_en++;
    if (clint_mtimecmp_en) n_cmp_en++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_sel(input logic [31:0] a);
    if (a == A_MTIME) return mtime_q;
    if (a == A_CMP) return mtimecmp_q;
    if (a == A_BASE) return {63'd0, msip_model};
    return 64'd0;
  endfunction

  task automatic do_req(input string tag, input logic [31:0] addr, input logic wen,
                        input logic [63:0] wdata, input logic [7:0] wstrb,
                        input logic exp_err, input int hold,
                        output logic [63:0] exec_wdata, output logic [63:0] exec_cur,
                        output logic [63:0] rdata);
    logic [63:0] exp_rd;
    int k;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_addr = addr; bus.req_wen = wen;
    bus.req_wdata = wdata; bus.req_wstrb = wstrb; bus.rsp_ready = 1'b0;
    k = 0;
    while (!bus.req_ready && k < 20) begin @(negedge clk); k++; end
    if (k == 20) check({tag, "_ready_timeout"}, 64'd0, 64'd1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    exec_wdata = clint_wdata;
    exec_cur   = model_sel(addr);
    exp_rd     = (exp_err || wen) ? 64'd0 : exec_cur;
    check({tag, "_exec_rsp_valid"}, {63'd0, bus.rsp_valid}, 64'd0);
    @(negedge clk);
    check({tag, "_rsp_valid_lat"}, {63'd0, bus.rsp_valid}, 64'd1);
    check({tag, "_rsp_err"}, {63'd0, bus.rsp_err}, {63'd0, exp_err});
    check({tag, "_rsp_rdata"}, bus.rsp_rdata, exp_rd);
    rdata = bus.rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, {63'd0, bus.rsp_valid}, 64'd1);
      check({tag, "_hold_req_ready"}, {63'd0, bus.req_ready}, 64'd0);
      check({tag, "_hold_rdata"}, bus.rsp_rdata, exp_rd);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
  endtask

  initial begin
    logic [63:0] ew, ec, rd;
    int m0, c0;
    bus.req_valid = 1'b0; bus.req_addr = '0; bus.req_wen = 1'b0;
    bus.req_wdata = '0; bus.req_wstrb = '0; bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", {63'd0, bus.req_ready}, 64'd0);
    check("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    check("rst_rdata", bus.rsp_rdata, 64'd0);
    check("rst_err", {63'd0, bus.rsp_err}, 64'd0);
    check("rst_wdata", clint_wdata, 64'd0);
    check("rst_en", {62'd0, clint_mtime_en, clint_mtimecmp_en}, 64'd0);
`ifdef CLINT_MSIP_EN
    check("rst_msip", {63'd0, msip_int}, 64'd0);
`endif
    reset = 1'b0;

    m0 = n_mt_en; c0 = n_cmp_en;
    do_req("wr_cmp_full", A_CMP, 1'b1, 64'h1000, 8'hFF, 1'b0, 0, ew, ec, rd);
    check("wr_cmp_full_wdata", ew, 64'h1000);
    check("wr_cmp_full_pulses", 64'(n_cmp_en - c0), 64'd1);
    check("wr_cmp_full_mt_pulses", 64'(n_mt_en - m0), 64'd0);

    do_req("wr_cmp_full2", A_CMP, 1'b1, 64'h1122_3344_5566_7788, 8'hFF, 1'b0, 0, ew, ec, rd);
    check("wr_cmp_full2_wdata", ew, 64'h1122_3344_5566_7788);
    do_req("wr_cmp_part", A_CMP, 1'b1, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 1'b0, 0, ew, ec, rd);
    check("wr_cmp_part_wdata", ew, 64'h1122_3344_AAAA_AAAA);
    do_req("rd_cmp", A_CMP, 1'b0, 64'h0, 8'h00, 1'b0, 0, ew, ec, rd);
    check("rd_cmp_value", rd, 64'h1122_3344_AAAA_AAAA);

    do_req("rd_mtime_bp", A_MTIME, 1'b0, 64'h0, 8'hFF, 1'b0, 5, ew, ec, rd);

    m0 = n_mt_en; c0 = n_cmp_en;
    do_req("rd_misalign", 32'h0200_4004, 1'b0, 64'h0, 8'hFF, 1'b1, 0, ew, ec, rd);
    do_req("rd_unmapped", 32'h0200_8000, 1'b0, 64'h0, 8'hFF, 1'b1, 0, ew, ec, rd);
    do_req("wr_misalign", 32'h0200_4004, 1'b1, 64'h55, 8'hFF, 1'b1, 0, ew, ec, rd);
    do_req("wr_unmapped", 32'h0200_8000, 1'b1, 64'h55, 8'hFF, 1'b1, 0, ew, ec, rd);
    do_req("wr_strb0", A_CMP, 1'b1, 64'h77, 8'h00, 1'b0, 0, ew, ec, rd);
    check("err_no_pulses", 64'(n_cmp_en - c0 + n_mt_en - m0), 64'd0);

    m0 = n_mt_en;
    do_req("wr_mtime_hi", A_MTIME, 1'b1, 64'hDEAD_BEEF_0000_0000, 8'hF0, 1'b0, 0, ew, ec, rd);
    check("wr_mtime_hi_wdata", ew, {32'hDEAD_BEEF, ec[31:0]});
    check("wr_mtime_hi_pulses", 64'(n_mt_en - m0), 64'd1);

`ifdef CLINT_MSIP_EN
    do_req("wr_msip1", A_BASE, 1'b1, 64'h1, 8'h01, 1'b0, 0, ew, ec, rd);
    msip_model = 1'b1;
    check("msip_set", {63'd0, msip_int}, 64'd1);
    do_req("rd_msip", A_BASE, 1'b0, 64'h0, 8'hFF, 1'b0, 0, ew, ec, rd);
    check("rd_msip_value", rd, 64'd1);
    do_req("wr_msip0", A_BASE, 1'b1, 64'h0, 8'h01, 1'b0, 0, ew, ec, rd);
    msip_model = 1'b0;
    check("msip_clr", {63'd0, msip_int}, 64'd0);
`else
    do_req("wr_base", A_BASE, 1'b1, 64'h1, 8'h01, 1'b1, 0, ew, ec, rd);
`endif

    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_addr = A_CMP; bus.req_wen = 1'b0;
    bus.req_wstrb = 8'hFF; bus.rsp_ready = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
    check("mid_rst_req_ready", {63'd0, bus.req_ready}, 64'd0);
    check("mid_rst_rdata", bus.rsp_rdata, 64'd0);
    check("mid_rst_wdata", clint_wdata, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    do_req("post_rst_rd", A_CMP, 1'b0, 64'h0, 8'hFF, 1'b0, 0, ew, ec, rd);
    check("post_rst_value", rd, 64'hFFFF_FFFF_FFFF_FFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/clint_bus_slave.md
Name: clint_bus_slave

Overview:
- Memory-mapped responder between the core's load/store bus and the CLINT timer block.
- Decodes core requests to the mtime/mtimecmp addresses.
- Drives the CLINT write port (shared wdata plus one-cycle enables) and returns CLINT register values on reads.
- Performs byte-strobe read-modify-write merging, because the CLINT only accepts full 64-bit writes.

Parameters:
- BASE_ADDR, 32'h0200_0000, CLINT region base.
- MTIMECMP_OFF, 32'h0000_4000, mtimecmp offset from BASE_ADDR.
- MTIME_OFF, 32'h0000_BFF8, mtime offset from BASE_ADDR.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_addr  in  32  byte address
- req_wen  in  1  1 = write, 0 = read
- req_wdata  in  64  write data
- req_wstrb  in  8  byte enables; bit i covers bits [8i+7:8i]
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_rdata  out  64  read data; 0 on writes and errors
- rsp_err  out  1  decode/alignment error
- clint_wdata  out  64  merged write value to CLINT
- clint_mtime_en  out  1  one-cycle mtime write pulse
- clint_mtimecmp_en  out  1  one-cycle mtimecmp write pulse
- clint_mtime_data  in  64  current mtime
- clint_mtimecmp_data  in  64  current mtimecmp
- msip_int  out  1  software interrupt (only with CLINT_MSIP_EN)

Behaviour:
- Reset: clk is the only clock; reset is asynchronous and active-high.
  - While reset is asserted: state=IDLE; req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, clint_wdata=0, both enables 0, msip_int=0.
  - A transaction in flight when reset asserts is dropped; no enable pulse and no response.
- FSM IDLE -> EXEC -> RESP -> IDLE.
  - IDLE: req_ready=1. On handshake, latch addr, wen, wdata, wstrb; go to EXEC.
  - EXEC (exactly 1 cycle): req_ready=0. Decode the latched address.
    - Write hit: drive clint_wdata and pulse the matching enable for this cycle only. rsp_err=0.
    - Read hit: capture the selected clint_*_data into rsp_rdata.
    - Go to RESP.
  - RESP: rsp_valid=1; rsp_rdata and rsp_err held stable until rsp_ready. On handshake, go to IDLE.
  - Back-pressure on rsp_ready stalls indefinitely in RESP; req_ready stays 0.
- Latency and throughput:
  - Request accepted at cycle N, rsp_valid rises at N+2.
  - With rsp_ready tied high, one transaction per 3 cycles.
- Decode:
  - hit = (latched addr == BASE_ADDR + offset), compared on all 32 bits.
  - If addr[2:0] != 0: rsp_err=1, rdata=0, no enable pulse.
  - Unmapped address: same treatment (rsp_err=1, rdata=0, no pulse).
- Write merge:
  - clint_wdata = (cur & ~M) | (latched_wdata & M), where M is the 64-bit expansion of wstrb.
  - cur is the selected clint_*_data sampled combinationally in the EXEC cycle.
  - mtime therefore keeps its live value in unstrobed bytes: the CLINT write takes priority over its own increment.
- wstrb == 0 write: no enable pulse; normal response with rsp_err=0.
- Reads ignore wstrb.
- Read-of-mtime value is the value present in the EXEC cycle; it is not incremented further.
- clint_wdata holds its last value outside EXEC. Enables are 0 outside EXEC.

Optional Feature:
- Macro: CLINT_MSIP_EN.
- Defined:
  - Adds a 1-bit msip register at BASE_ADDR+0x0 (64-bit slot).
  - Write with wstrb[0]=1 loads wdata[0] at the end of EXEC.
  - Read returns {63'b0, msip}.
  - msip_int = msip register; reset value 0.
- Undefined:
  - msip_int port absent.
  - BASE_ADDR+0x0 is unmapped, so accesses get rsp_err=1.

Test Plan:
- Reset mid-RESP with rsp_ready=0 -> outputs return to reset values immediately; next request is accepted normally.
- Full write 0x0000_0000_0000_1000 to 0x0200_4000 with wstrb=0xFF -> clint_mtimecmp_en high for exactly 1 cycle with clint_wdata=0x1000; rsp_valid at N+2; rsp_err=0.
- mtimecmp=0x1122_3344_5566_7788, write wdata=0xAAAA_AAAA_AAAA_AAAA with wstrb=0x0F -> clint_wdata=0x1122_3344_AAAA_AAAA.
- Read 0x0200_BFF8 while the CLINT counts -> rsp_rdata equals clint_mtime_data in the EXEC cycle; hold rsp_ready=0 for 5 cycles -> rdata unchanged and req_ready=0 throughout.
- Read 0x0200_4004 (misaligned) and read 0x0200_8000 (unmapped) -> each gives rsp_err=1, rdata=0, no enable pulse.
- With CLINT_MSIP_EN: write 1 to 0x0200_0000 -> msip_int=1 after EXEC; read returns 1; write 0 -> msip_int=0. Without CLINT_MSIP_EN: same write -> rsp_err=1.
